// File: rtl/br_enc_priority_encoder_iter.sv
// Iterative multi-grant priority encoder: holds a request vector as a residual set and
// emits up to NumResults one-hot grants per beat, lowest index first, until it is empty.

module br_enc_priority_encoder_iter #(
  parameter int NumRequesters = 8,
  parameter int NumResults    = 2,
  localparam int CountWidth   = $clog2(NumResults + 1),
  localparam int IdxWidth     = $clog2(NumRequesters)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [NumRequesters-1:0]                  in,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [NumResults-1:0][NumRequesters-1:0]  out,
  output logic [NumResults-1:0][IdxWidth-1:0]       out_idx,
  output logic [CountWidth-1:0]                     out_count,
  output logic                                      out_last
);

  localparam logic [NumRequesters-1:0] LsbOne = {{(NumRequesters-1){1'b0}}, 1'b1};

  logic [NumRequesters-1:0]                  residual_r;
  logic                                      accept_s;
  logic                                      advance_s;
  logic [NumRequesters-1:0]                  src_s;
  logic [NumRequesters-1:0]                  rem_s;
  logic [NumResults-1:0][NumRequesters-1:0]  grant_s;
  logic [NumResults-1:0][IdxWidth-1:0]       idx_s;
  logic [CountWidth-1:0]                     count_s;

  assign in_ready  = !out_valid || (out_ready && out_last);
  assign accept_s  = in_valid && in_ready;
  assign advance_s = out_valid && out_ready && !out_last;

  // Peel the lowest set bits off the selected source, one grant slot at a time.
  always_comb begin
    src_s   = accept_s ? in : residual_r;
    rem_s   = src_s;
    grant_s = '0;
    idx_s   = '0;
    count_s = '0;
    for (int k = 0; k < NumResults; k++) begin
      grant_s[k] = rem_s & (~rem_s + LsbOne);
      rem_s      = rem_s & ~grant_s[k];
      if (grant_s[k] != '0) begin
        count_s = count_s + CountWidth'(1);
      end else begin
        count_s = count_s;
      end
      for (int i = 0; i < NumRequesters; i++) begin
        if (grant_s[k][i]) begin
          idx_s[k] = IdxWidth'(i);
        end else begin
          idx_s[k] = idx_s[k];
        end
      end
    end
  end

  // Residual and registered output beat; a new vector may load as the last beat leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      residual_r <= '0;
      out_valid  <= 1'b0;
      out        <= '0;
      out_idx    <= '0;
      out_count  <= '0;
      out_last   <= 1'b0;
    end else if (accept_s || advance_s) begin
      residual_r <= rem_s;
      out_valid  <= 1'b1;
      out        <= grant_s;
      out_idx    <= idx_s;
      out_count  <= count_s;
      out_last   <= (rem_s == '0);
    end else if (out_valid && out_ready) begin
      residual_r <= '0;
      out_valid  <= 1'b0;
      out        <= '0;
      out_idx    <= '0;
      out_count  <= '0;
      out_last   <= 1'b0;
    end
  end

  br_enc_priority_encoder_iter_chk #(
    .NumRequesters(NumRequesters),
    .NumResults   (NumResults)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .out_count(out_count),
    .out_last (out_last)
  );

endmodule

// Protocol and beat-integrity checks for br_enc_priority_encoder_iter.
module br_enc_priority_encoder_iter_chk #(
  parameter int NumRequesters = 8,
  parameter int NumResults    = 2,
  localparam int CountWidth   = $clog2(NumResults + 1)
) (
  input logic                                      clk,
  input logic                                      rst,
  input logic                                      in_valid,
  input logic                                      in_ready,
  input logic [NumRequesters-1:0]                  in,
  input logic                                      out_valid,
  input logic                                      out_ready,
  input logic [NumResults-1:0][NumRequesters-1:0]  out,
  input logic [CountWidth-1:0]                     out_count,
  input logic                                      out_last
);

  localparam logic [NumRequesters-1:0] LsbOne = {{(NumRequesters-1){1'b0}}, 1'b1};

  logic [NumRequesters-1:0] union_s;
  logic                     onehot_ok_s;
  logic                     excl_ok_s;
  logic                     pop_ok_s;

  // Fold the grant slots into one-hot, exclusivity and population summaries.
  always_comb begin
    union_s     = '0;
    onehot_ok_s = 1'b1;
    excl_ok_s   = 1'b1;
    for (int k = 0; k < NumResults; k++) begin
      if ((out[k] & (out[k] - LsbOne)) != '0) begin
        onehot_ok_s = 1'b0;
      end else begin
        onehot_ok_s = onehot_ok_s;
      end
      if ((union_s & out[k]) != '0) begin
        excl_ok_s = 1'b0;
      end else begin
        excl_ok_s = excl_ok_s;
      end
      union_s = union_s | out[k];
    end
    pop_ok_s = ($countones(union_s) == int'(out_count));
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) out_valid |-> onehot_ok_s && excl_ok_s);
  a_pop:    assert property (@(posedge clk) disable iff (rst) out_valid |-> pop_ok_s);
  a_drop:   assert property (@(posedge clk) $fell(out_valid) |-> $past(rst) || $past(out_ready && out_last));
  a_stable: assert property (@(posedge clk) disable iff (rst) (in_valid && !in_ready) |=> $stable(in));
  a_known:  assert property (@(posedge clk) disable iff (rst) !$isunknown(in_valid));

endmodule

// File: tb/tb_br_enc_priority_encoder_iter.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor compares them.

module tb_br_enc_priority_encoder_iter;

  typedef struct {
    logic [1:0][7:0] o;
    logic [1:0][2:0] idx;
    logic [1:0]      cnt;
    logic            last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      req;
  logic            out_valid;
  logic            out_ready;
  logic [1:0][7:0] out;
  logic [1:0][2:0] out_idx;
  logic [1:0]      out_count;
  logic            out_last;

  logic            in_valid4;
  logic            in_ready4;
  logic [3:0]      req4;
  logic            out_valid4;
  logic            out_ready4;
  logic [3:0][3:0] out4;
  logic [3:0][1:0] out_idx4;
  logic [2:0]      out_count4;
  logic            out_last4;

  int    checks = 0;
  int    failures = 0;
  logic  rand_mode = 1'b0;
  beat_t sb[$];

  always #5 clk = ~clk;

  br_enc_priority_encoder_iter #(.NumRequesters(8), .NumResults(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(req),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_idx(out_idx),
    .out_count(out_count), .out_last(out_last)
  );

  br_enc_priority_encoder_iter #(.NumRequesters(4), .NumResults(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in(req4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out(out4), .out_idx(out_idx4),
    .out_count(out_count4), .out_last(out_last4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] o0, input logic [7:0] o1, input logic [2:0] i0,
                      input logic [2:0] i1, input logic [1:0] c, input logic l);
    beat_t b;
    b.o[0] = o0; b.o[1] = o1; b.idx[0] = i0; b.idx[1] = i1; b.cnt = c; b.last = l;
    sb.push_back(b);
  endtask

  // Reference: list set bits in ascending order and chunk them two per beat.
  task automatic model(input logic [7:0] v);
    int         bits[$];
    logic [7:0] one8;
    logic [7:0] o0, o1;
    logic [2:0] i0, i1;
    one8 = 8'h01;
    for (int i = 0; i < 8; i++) if (v[i]) bits.push_back(i);
    if (bits.size() == 0) begin
      push(8'h00, 8'h00, 3'd0, 3'd0, 2'd0, 1'b1);
    end else begin
      for (int j = 0; j < bits.size(); j += 2) begin
        o0 = one8 << bits[j];
        i0 = 3'(bits[j]);
        if (j + 1 < bits.size()) begin
          o1 = one8 << bits[j+1];
          i1 = 3'(bits[j+1]);
        end else begin
          o1 = 8'h00;
          i1 = 3'd0;
        end
        push(o0, o1, i0, i1, (j + 1 < bits.size()) ? 2'd2 : 2'd1, (j + 2 >= bits.size()));
      end
    end
  endtask

  task automatic send(input logic [7:0] v, output int n);
    logic rdy;
    in_valid = 1'b1;
    req = v;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    in_valid = 1'b0;
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept expected=accept vec=0x%0h", v);
    end else begin
      chk("first_beat_latency", out_valid, 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0_pending", sb.size());
    end
  endtask

  // Monitor: every valid cycle must match the queue head; pop when the beat transfers.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=out0x%0h expected=no_beat", out);
        end else begin
          chk("out0", out[0], sb[0].o[0]);
          chk("out1", out[1], sb[0].o[1]);
          chk("idx0", out_idx[0], sb[0].idx[0]);
          chk("idx1", out_idx[1], sb[0].idx[1]);
          chk("count", out_count, sb[0].cnt);
          chk("last", out_last, sb[0].last);
          chk("in_ready_busy", in_ready, out_ready ? 32'(sb[0].last) : 32'd0);
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("in_ready_idle", in_ready, 1);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2;
    logic [7:0] v;
    rst = 1'b1; in_valid = 1'b0; req = 8'h00; out_ready = 1'b1;
    in_valid4 = 1'b0; req4 = 4'h0; out_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_count", out_count, 0);
    chk("rst_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid4", out_valid4, 0);
    rst = 1'b0;

    // 0xB6: bits 1,2,4,5,7
    push(8'h02, 8'h04, 3'd1, 3'd2, 2'd2, 1'b0);
    push(8'h10, 8'h20, 3'd4, 3'd5, 2'd2, 1'b0);
    push(8'h80, 8'h00, 3'd7, 3'd0, 2'd1, 1'b1);
    send(8'hB6, n);
    drain();

    push(8'h00, 8'h00, 3'd0, 3'd0, 2'd0, 1'b1);
    send(8'h00, n);
    drain();

    // Stall on the first beat of 0xFF
    out_ready = 1'b0;
    push(8'h01, 8'h02, 3'd0, 3'd1, 2'd2, 1'b0);
    push(8'h04, 8'h08, 3'd2, 3'd3, 2'd2, 1'b0);
    push(8'h10, 8'h20, 3'd4, 3'd5, 2'd2, 1'b0);
    push(8'h40, 8'h80, 3'd6, 3'd7, 2'd2, 1'b1);
    send(8'hFF, n);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Back-to-back single-bit vectors
    push(8'h01, 8'h00, 3'd0, 3'd0, 2'd1, 1'b1);
    push(8'h80, 8'h00, 3'd7, 3'd0, 2'd1, 1'b1);
    send(8'h01, n);
    send(8'h80, n2);
    chk("b2b_first_wait", n, 1);
    chk("b2b_second_wait", n2, 1);
    drain();

    // Reset during the second beat of 0xFF
    push(8'h01, 8'h02, 3'd0, 3'd1, 2'd2, 1'b0);
    push(8'h04, 8'h08, 3'd2, 3'd3, 2'd2, 1'b0);
    push(8'h10, 8'h20, 3'd4, 3'd5, 2'd2, 1'b0);
    push(8'h40, 8'h80, 3'd6, 3'd7, 2'd2, 1'b1);
    send(8'hFF, n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_last", out_last, 0);
    push(8'h08, 8'h00, 3'd3, 3'd0, 2'd1, 1'b1);
    send(8'h08, n);
    drain();

    // Four-wide instance: 0xF in a single beat
    req4 = 4'hF;
    in_valid4 = 1'b1;
    @(negedge clk);
    chk("w4_in_ready", in_ready4, 1);
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    chk("w4_valid", out_valid4, 1);
    chk("w4_out", out4, 32'h8421);
    chk("w4_idx", out_idx4, 32'hE4);
    chk("w4_count", out_count4, 4);
    chk("w4_last", out_last4, 1);
    @(posedge clk);
    #1;
    chk("w4_drop", out_valid4, 0);

    // Random vectors with random backpressure against the reference
    rand_mode = 1'b1;
    for (int t = 0; t < 10000; t++) begin
      v = 8'($urandom);
      model(v);
      send(v, n);
    end
    rand_mode = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
